// File: rtl/cpu_dbg_pkg.sv
// Shared constants and types for the CPU debug-state transmitter.
// Frame layout: 4 header words, 32 registers, 8 data-memory words.
package cpu_dbg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StSend
   } dump_state_e;

   localparam int unsigned FRAME_WORDS = 44;
   localparam int unsigned HDR_WORDS   = 4;
   localparam int unsigned REG_BASE    = 4;
   localparam int unsigned MEM_BASE    = 36;
   localparam int unsigned IDX_W       = 6;

   localparam int unsigned HDR_CYC   = 0;
   localparam int unsigned HDR_STALL = 1;
   localparam int unsigned HDR_FLUSH = 2;
   localparam int unsigned HDR_PC    = 3;

endpackage

// File: rtl/dbg_counters.sv
// Free-running, start-gated cycle/stall/flush counters that wrap modulo 2^DATA_W.
// On capture, the pre-increment counter values and the PC are latched as the frame header.
module dbg_counters
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_start,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_capture,
   input  logic [DATA_W-1:0] i_pc,
   output logic [DATA_W-1:0] o_snap_cyc,
   output logic [DATA_W-1:0] o_snap_stall,
   output logic [DATA_W-1:0] o_snap_flush,
   output logic [DATA_W-1:0] o_snap_pc
);

   logic [DATA_W-1:0] r_cyc_cnt;
   logic [DATA_W-1:0] r_stall_cnt;
   logic [DATA_W-1:0] r_flush_cnt;
   logic [DATA_W-1:0] r_snap_cyc;
   logic [DATA_W-1:0] r_snap_stall;
   logic [DATA_W-1:0] r_snap_flush;
   logic [DATA_W-1:0] r_snap_pc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cyc_cnt   <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (i_start) begin
         r_cyc_cnt <= r_cyc_cnt + DATA_W'(1);
         if (i_stall) r_stall_cnt <= r_stall_cnt + DATA_W'(1);
         if (i_flush) r_flush_cnt <= r_flush_cnt + DATA_W'(1);
      end
   end

   // Snapshot sees the counters as they were before this edge's increment.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_snap_cyc   <= '0;
         r_snap_stall <= '0;
         r_snap_flush <= '0;
         r_snap_pc    <= '0;
      end else if (i_capture) begin
         r_snap_cyc   <= r_cyc_cnt;
         r_snap_stall <= r_stall_cnt;
         r_snap_flush <= r_flush_cnt;
         r_snap_pc    <= i_pc;
      end
   end

   assign o_snap_cyc   = r_snap_cyc;
   assign o_snap_stall = r_snap_stall;
   assign o_snap_flush = r_snap_flush;
   assign o_snap_pc    = r_snap_pc;

endmodule

// File: rtl/state_dump_tx.sv
// Debug-state frame transmitter: header snapshot, then a live scan of registers and memory,
// streamed one word per valid/ready handshake.
module state_dump_tx
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned NUM_REGS      = 32,
   parameter int unsigned NUM_MEM_WORDS = 8,
   parameter int unsigned DATA_W        = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] pc_i,
   input  logic              dump_req_i,
   output logic [4:0]        reg_addr_o,
   input  logic [DATA_W-1:0] reg_data_i,
   output logic [4:0]        mem_addr_o,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic [DATA_W-1:0] tx_data_o,
   output logic              tx_last_o,
   output logic              busy_o
);

   localparam logic [IDX_W-1:0] LP_REG_BASE = IDX_W'(REG_BASE);
   localparam logic [IDX_W-1:0] LP_REG_END  = IDX_W'(REG_BASE + NUM_REGS);
   localparam logic [IDX_W-1:0] LP_MEM_BASE = IDX_W'(MEM_BASE);
   localparam logic [IDX_W-1:0] LP_LAST     = IDX_W'(MEM_BASE + NUM_MEM_WORDS - 1);
   localparam logic [IDX_W-1:0] LP_HDR_END  = IDX_W'(HDR_WORDS);

   dump_state_e       r_state;
   dump_state_e       w_state_next;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_tx_data;
   logic [DATA_W-1:0] w_fetch_data;
   logic              w_capture;
   logic              w_in_reg;
   logic              w_in_mem;
   logic [4:0]        w_reg_off;
   logic [2:0]        w_mem_off;
   logic [DATA_W-1:0] w_snap_cyc;
   logic [DATA_W-1:0] w_snap_stall;
   logic [DATA_W-1:0] w_snap_flush;
   logic [DATA_W-1:0] w_snap_pc;

   assign w_capture = (r_state == StIdle) && dump_req_i;
   assign w_in_reg  = (r_idx >= LP_REG_BASE) && (r_idx < LP_REG_END);
   assign w_in_mem  = (r_idx >= LP_MEM_BASE);
   assign w_reg_off = 5'(r_idx - LP_REG_BASE);
   assign w_mem_off = 3'(r_idx - LP_MEM_BASE);

   dbg_counters #(
      .DATA_W (DATA_W)
   ) u_counters (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .i_start      (start_i),
      .i_stall      (stall_i),
      .i_flush      (flush_i),
      .i_capture    (w_capture),
      .i_pc         (pc_i),
      .o_snap_cyc   (w_snap_cyc),
      .o_snap_stall (w_snap_stall),
      .o_snap_flush (w_snap_flush),
      .o_snap_pc    (w_snap_pc)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (dump_req_i) w_state_next = StFetch;
         StFetch: w_state_next = StSend;
         StSend:  if (tx_ready_i) w_state_next = (r_idx == LP_LAST) ? StIdle : StFetch;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_fetch_data = '0;
      if (r_idx < LP_HDR_END) begin
         case (r_idx[1:0])
            2'(HDR_CYC):   w_fetch_data = w_snap_cyc;
            2'(HDR_STALL): w_fetch_data = w_snap_stall;
            2'(HDR_FLUSH): w_fetch_data = w_snap_flush;
            default:       w_fetch_data = w_snap_pc;
         endcase
      end else if (w_in_reg) begin
         w_fetch_data = reg_data_i;
      end else if (w_in_mem) begin
         w_fetch_data = mem_data_i;
      end
   end

   // Index and data change only on FETCH->SEND or an accepted handshake, so SEND is stable.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_idx     <= '0;
         r_tx_data <= '0;
      end else begin
         unique case (r_state)
            StIdle:  if (dump_req_i) r_idx <= '0;
            StFetch: r_tx_data <= w_fetch_data;
            StSend:  if (tx_ready_i && (r_idx != LP_LAST)) r_idx <= r_idx + IDX_W'(1);
            default: r_idx <= '0;
         endcase
      end
   end

   always_comb begin
      reg_addr_o = '0;
      mem_addr_o = '0;
      if (r_state == StFetch) begin
         if (w_in_reg) reg_addr_o = w_reg_off;
         if (w_in_mem) mem_addr_o = {w_mem_off, 2'b00};
      end
      tx_valid_o = (r_state == StSend);
      tx_last_o  = (r_state == StSend) && (r_idx == LP_LAST);
      busy_o     = (r_state != StIdle);
      tx_data_o  = r_tx_data;
   end

endmodule
